scheduler_multipass: RTL
========================

Name: scheduler_multipass

Overview:
- Parametrised successor to the accelerator round scheduler.
- Sequences positioner, image/filter broadcast, allocator and writeback per output position.
- Adds: explicit start, configurable positioner headstart, multiple filter passes per position, writeback handshake, broadcast watchdog with error state, round counter.
- Sits at the top of the accelerator core, driving the resets and enables of all datapath sub-blocks.

Parameters:
- HEADSTART_DELAY, 2: cycles spent in HEADSTART (0 = skip state); range 0..2^DELAY_W-1
- DELAY_W, 4: width of headstart counter
- NUM_PASSES, 1: filter passes per positioner position (>=1)
- PASS_W, 4: width of filter_pass
- ROUND_W, 16: width of round_count
- TIMEOUT, 1024: max cycles in BROADCASTING before error (0 = watchdog disabled)
- TIMEOUT_W, 11: width of watchdog counter

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-low reset
- start  in  1  begin job; sampled in IDLE and DONE only
- positioner_round  in  1  positioner finished current round
- positioner_done  in  1  positioner has no further positions
- positioner_advance  out  1  step positioner to next position
- positioner_rst  out  1  positioner reset
- image_broadcast_round  in  1  image broadcast finished round
- image_broadcast_rst  out  1  image broadcast reset
- filter_broadcast_done  in  1  filter broadcast finished pass
- filter_broadcast_rst  out  1  filter broadcast reset
- filter_pass  out  PASS_W  current pass index, 0..NUM_PASSES-1
- allocator_done  in  1  allocator finished
- allocator_rst  out  1  allocator reset
- writeback_en  out  1  request writeback
- writeback_done  in  1  writeback accepted
- writeback_rst  out  1  writeback reset
- accel_busy  out  1  job in progress
- accel_done  out  1  job complete
- accel_error  out  1  watchdog expired
- round_count  out  ROUND_W  completed rounds this job

Behaviour:
- States: IDLE, START_ROUND, HEADSTART, BROADCASTING, WRITEBACK, DONE, ERROR.
- Registers: state, filter_pass, round_count, delay and watchdog counters.
- All control outputs are Moore decodes of state.
- Reset (rst=0, asynchronous): state=IDLE, filter_pass=0, round_count=0, counters=0.
- Outputs while in reset and in IDLE:
  - all *_rst=1
  - positioner_advance=0, writeback_en=0
  - accel_busy=0, accel_done=0, accel_error=0
- Reset asserted mid-job forces IDLE outputs immediately, without waiting for clk.
- IDLE: start=1 -> START_ROUND; round_count and filter_pass cleared.
- START_ROUND (exactly 1 cycle):
  - positioner_advance = 1 iff filter_pass==0
  - image/filter/allocator rst=1, positioner_rst=0, writeback_rst=0
  - -> HEADSTART, or -> BROADCASTING if HEADSTART_DELAY==0
- HEADSTART:
  - image_broadcast_rst=1; filter, allocator and positioner rst=0
  - remains exactly HEADSTART_DELAY cycles (counter 0..HEADSTART_DELAY-1), then -> BROADCASTING
- BROADCASTING:
  - all *_rst=0
  - exits to WRITEBACK on the first cycle where image_broadcast_round, positioner_round, allocator_done and filter_broadcast_done are all 1 in the same cycle
  - watchdog clears on entry and increments each cycle
  - if TIMEOUT!=0 and the count reaches TIMEOUT-1 without exit -> ERROR
  - completion wins over timeout on the same cycle
- WRITEBACK:
  - writeback_en=1, image/filter rst=1, allocator_rst=0
  - held until writeback_done=1; on that edge round_count increments (wraps at 2^ROUND_W)
  - if filter_pass < NUM_PASSES-1: filter_pass++, -> START_ROUND (no advance)
  - else: filter_pass=0, then -> DONE if positioner_done (sampled on the same edge), else -> START_ROUND
- DONE:
  - accel_done=1, all *_rst=1, accel_busy=0
  - round_count holds
  - start=1 -> START_ROUND with counters cleared
- ERROR:
  - accel_error=1, all *_rst=1, accel_busy=0
  - sticky until rst; start ignored
- accel_busy=1 in START_ROUND, HEADSTART, BROADCASTING, WRITEBACK.
- start is ignored while busy.

Test Plan:
- Reset then start, HEADSTART_DELAY=2, NUM_PASSES=1; all done inputs=1; writeback_done=1; positioner_done=1 -> sequence START(1)/HEADSTART(2)/BROADCAST(1)/WRITEBACK(1)/DONE; positioner_advance pulses once; round_count=1; accel_done=1.
- NUM_PASSES=3, positioner_done=0 for 2 positions, then 1 -> filter_pass cycles 0,1,2,0,1,2; positioner_advance pulses only at pass 0 (2 pulses); DONE with round_count=6.
- Inputs rise on different cycles (image@+3, allocator@+5, filter@+7, positioner_round@+9) -> exit BROADCASTING only on the cycle after +9; writeback_en held 4 cycles until writeback_done.
- TIMEOUT=16, allocator_done held 0 -> ERROR after 16 BROADCASTING cycles; accel_error=1 and all rst=1; start ignored; rst low clears to IDLE.
- HEADSTART_DELAY=0 -> START_ROUND goes directly to BROADCASTING; image_broadcast_rst low on the next cycle.
- Async reset asserted mid-WRITEBACK between clock edges -> outputs take IDLE values before the next edge; round_count=0.

Source files
------------

// File: rtl/scheduler_multipass.sv
// scheduler_multipass
//   Top-level round scheduler for the accelerator core. For each output
//   position it steps the positioner, runs one or more filter passes
//   (image/filter broadcast + allocator), then hands the result to writeback.
//   It drives the resets/enables of every datapath sub-block and reports
//   job status.
//
// Ports:
//   clk, rst                 clock (rising edge), async active-low reset
//   start                    begin a job (honoured in IDLE and DONE only)
//   positioner_*             round/done status in, advance/reset out
//   image_broadcast_*        round status in, reset out
//   filter_broadcast_*       pass-done status in, reset out
//   filter_pass              current filter pass index
//   allocator_*              done status in, reset out
//   writeback_*              en/done handshake, reset out
//   accel_busy/done/error    job status
//   round_count              rounds completed in the current job
//
// state        | meaning
// -------------+-----------------------------------------------------------
// IDLE         | waiting for start, all sub-blocks held in reset
// START_ROUND  | one cycle: advance positioner on pass 0, reset broadcasters
// HEADSTART    | positioner runs ahead while image broadcast stays in reset
// BROADCASTING | all sub-blocks running, watchdog counting
// WRITEBACK    | writeback requested, waiting for writeback_done
// DONE         | job complete, round_count held
// ERROR        | watchdog expired, sticky until reset

module scheduler_multipass #(
  parameter int HEADSTART_DELAY = 2,
  parameter int DELAY_W         = 4,
  parameter int NUM_PASSES      = 1,
  parameter int PASS_W          = 4,
  parameter int ROUND_W         = 16,
  parameter int TIMEOUT         = 1024,
  parameter int TIMEOUT_W       = 11
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               positioner_round,
  input  logic               positioner_done,
  output logic               positioner_advance,
  output logic               positioner_rst,
  input  logic               image_broadcast_round,
  output logic               image_broadcast_rst,
  input  logic               filter_broadcast_done,
  output logic               filter_broadcast_rst,
  output logic [PASS_W-1:0]  filter_pass,
  input  logic               allocator_done,
  output logic               allocator_rst,
  output logic               writeback_en,
  input  logic               writeback_done,
  output logic               writeback_rst,
  output logic               accel_busy,
  output logic               accel_done,
  output logic               accel_error,
  output logic [ROUND_W-1:0] round_count
);

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_HEAD, S_BCAST, S_WB, S_DONE, S_ERROR
  } state_t;

  // Clamped so the casts below stay legal when the feature is disabled.
  localparam int HS_LAST   = (HEADSTART_DELAY > 0) ? HEADSTART_DELAY - 1 : 0;
  localparam int WD_LAST   = (TIMEOUT > 0) ? TIMEOUT - 1 : 0;
  localparam int PASS_LAST = (NUM_PASSES > 0) ? NUM_PASSES - 1 : 0;

  state_t               state, state_next;
  logic [DELAY_W-1:0]   delay_cnt;
  logic [TIMEOUT_W-1:0] wd_cnt;

  logic delay_last, bcast_complete, wd_expire, last_pass;

  assign delay_last     = (delay_cnt == DELAY_W'(HS_LAST));
  assign bcast_complete = image_broadcast_round & positioner_round &
                          allocator_done & filter_broadcast_done;
  assign wd_expire      = (TIMEOUT != 0) && (wd_cnt == TIMEOUT_W'(WD_LAST));
  assign last_pass      = (filter_pass == PASS_W'(PASS_LAST));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= S_IDLE;
    else      state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:  if (start) state_next = S_START;
      S_START: state_next = (HEADSTART_DELAY == 0) ? S_BCAST : S_HEAD;
      S_HEAD:  if (delay_last) state_next = S_BCAST;
      // Completion is tested first so it wins over a same-cycle timeout.
      S_BCAST: begin
        if (bcast_complete) state_next = S_WB;
        else if (wd_expire) state_next = S_ERROR;
      end
      S_WB: begin
        if (writeback_done) begin
          if (!last_pass)           state_next = S_START;
          else if (positioner_done) state_next = S_DONE;
          else                      state_next = S_START;
        end
      end
      S_DONE:  if (start) state_next = S_START;
      S_ERROR: state_next = S_ERROR;
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      filter_pass <= '0;
      round_count <= '0;
      delay_cnt   <= '0;
      wd_cnt      <= '0;
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          if (start) begin
            filter_pass <= '0;
            round_count <= '0;
          end
        end
        S_START: begin
          delay_cnt <= '0;
          wd_cnt    <= '0;
        end
        S_HEAD:  delay_cnt <= delay_cnt + DELAY_W'(1);
        S_BCAST: wd_cnt    <= wd_cnt + TIMEOUT_W'(1);
        S_WB: begin
          if (writeback_done) begin
            round_count <= round_count + ROUND_W'(1);
            filter_pass <= last_pass ? '0 : filter_pass + PASS_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    positioner_advance   = 1'b0;
    positioner_rst       = 1'b1;
    image_broadcast_rst  = 1'b1;
    filter_broadcast_rst = 1'b1;
    allocator_rst        = 1'b1;
    writeback_rst        = 1'b1;
    writeback_en         = 1'b0;
    accel_busy           = 1'b0;
    accel_done           = 1'b0;
    accel_error          = 1'b0;
    case (state)
      S_START: begin
        // Later passes reuse the same position, so only pass 0 advances.
        positioner_advance = (filter_pass == '0);
        positioner_rst     = 1'b0;
        writeback_rst      = 1'b0;
        accel_busy         = 1'b1;
      end
      S_HEAD: begin
        positioner_rst       = 1'b0;
        filter_broadcast_rst = 1'b0;
        allocator_rst        = 1'b0;
        writeback_rst        = 1'b0;
        accel_busy           = 1'b1;
      end
      S_BCAST: begin
        positioner_rst       = 1'b0;
        image_broadcast_rst  = 1'b0;
        filter_broadcast_rst = 1'b0;
        allocator_rst        = 1'b0;
        writeback_rst        = 1'b0;
        accel_busy           = 1'b1;
      end
      S_WB: begin
        positioner_rst = 1'b0;
        allocator_rst  = 1'b0;
        writeback_rst  = 1'b0;
        writeback_en   = 1'b1;
        accel_busy     = 1'b1;
      end
      S_DONE:  accel_done  = 1'b1;
      S_ERROR: accel_error = 1'b1;
      default: ;
    endcase
  end

endmodule
